// File: rtl/uart_cmd_decoder_pkg.sv
// uart_cmd_decoder_pkg: command codes, ack bytes and FSM states shared by the Pong control path
package uart_cmd_decoder_pkg;
  localparam logic [7:0] CMD_START = 8'h53;
  localparam logic [7:0] CMD_RESET = 8'h52;
  localparam logic [7:0] CMD_PAUSE = 8'h50;
  localparam logic [7:0] CMD_SPEED = 8'h44;
  localparam logic [7:0] ACK_OK    = 8'h4B;
  localparam logic [7:0] ACK_ERR   = 8'h3F;
  typedef enum logic {IDLE, WAIT_ARG} state_t;
endpackage

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder: decodes UART bytes into Pong game controls and queues a one-byte ack for TX
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int TIMEOUT_CLKS  = 2500000,
  parameter int DEFAULT_SPEED = 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_TX_Active,
  output logic       o_Game_Start,
  output logic       o_Game_Reset,
  output logic       o_Pause,
  output logic [1:0] o_Ball_Speed,
  output logic       o_Cmd_Err,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte
);
  localparam int CW = $clog2(TIMEOUT_CLKS);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CLKS - 1);
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic start_q, start_d, greset_q, greset_d, err_q, err_d, pause_q, pause_d;
  logic [1:0] speed_q, speed_d;
  logic ack_pend_q, ack_pend_d, tx_dv_q, tx_dv_d;
  logic [7:0] ack_byte_q, ack_byte_d, tx_byte_q, tx_byte_d, ack_v;
  logic queue, send;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_d = 1'b0;
    greset_d = 1'b0;
    err_d   = 1'b0;
    pause_d = pause_q;
    speed_d = speed_q;
    queue   = 1'b0;
    ack_v   = ACK_OK;
    if (state_q == IDLE) begin
      if (i_RX_DV) begin
        queue = 1'b1;
        if (i_RX_Byte == CMD_START) begin
          start_d = 1'b1;
          pause_d = 1'b0;
        end else if (i_RX_Byte == CMD_RESET) begin
          greset_d = 1'b1;
          pause_d  = 1'b0;
        end else if (i_RX_Byte == CMD_PAUSE) begin
          pause_d = !pause_q;
        end else if (i_RX_Byte == CMD_SPEED) begin
          state_d = WAIT_ARG;
          cnt_d   = '0;
          queue   = 1'b0;
        end else begin
          err_d = 1'b1;
          ack_v = ACK_ERR;
        end
      end
    end else if (i_RX_DV) begin
      // a byte arriving on the timeout cycle is taken as the argument
      state_d = IDLE;
      queue   = 1'b1;
      err_d   = i_RX_Byte > 8'h03;
      ack_v   = err_d ? ACK_ERR : ACK_OK;
      speed_d = err_d ? speed_q : i_RX_Byte[1:0];
    end else if (cnt_q == LAST) begin
      state_d = IDLE;
      queue   = 1'b1;
      err_d   = 1'b1;
      ack_v   = ACK_ERR;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    send       = ack_pend_q && !i_TX_Active;
    ack_pend_d = queue || (ack_pend_q && !send);
    ack_byte_d = queue ? ack_v : ack_byte_q;
    tx_dv_d    = send;
    tx_byte_d  = send ? ack_byte_q : tx_byte_q;
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      greset_q   <= 1'b0;
      err_q      <= 1'b0;
      pause_q    <= 1'b0;
      speed_q    <= 2'(DEFAULT_SPEED);
      ack_pend_q <= 1'b0;
      ack_byte_q <= 8'h00;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      greset_q   <= greset_d;
      err_q      <= err_d;
      pause_q    <= pause_d;
      speed_q    <= speed_d;
      ack_pend_q <= ack_pend_d;
      ack_byte_q <= ack_byte_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end
  assign o_Game_Start = start_q;
  assign o_Game_Reset = greset_q;
  assign o_Cmd_Err    = err_q;
  assign o_Pause      = pause_q;
  assign o_Ball_Speed = speed_q;
  assign o_TX_DV      = tx_dv_q;
  assign o_TX_Byte    = tx_byte_q;
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// tb_uart_cmd_decoder: directed byte sequences; pulses and acks are checked against a scoreboard
module tb_uart_cmd_decoder;
  localparam int TO = 16;
  localparam logic [2:0] P_START = 3'b100, P_RESET = 3'b010, P_ERR = 3'b001, P_NONE = 3'b000;
  localparam logic [7:0] K = 8'h4B, Q = 8'h3F, NOACK = 8'h00;
  typedef struct {
    logic [7:0] v;
    int c;
  } exp_t;
  logic clk, rst, rx_dv, tx_active;
  logic [7:0] rx_byte;
  logic game_start, game_reset, pause, cmd_err, tx_dv;
  logic [1:0] speed;
  logic [7:0] tx_byte;
  int cyc = 0;
  int vectors = 0;
  int miss = 0;
  exp_t exp_tx[$];
  exp_t exp_p[$];
  uart_cmd_decoder #(.TIMEOUT_CLKS(TO), .DEFAULT_SPEED(1)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_RX_DV(rx_dv), .i_RX_Byte(rx_byte), .i_TX_Active(tx_active),
    .o_Game_Start(game_start), .o_Game_Reset(game_reset), .o_Pause(pause),
    .o_Ball_Speed(speed), .o_Cmd_Err(cmd_err), .o_TX_DV(tx_dv), .o_TX_Byte(tx_byte)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    exp_t e;
    if (tx_dv) begin
      vectors++;
      if (exp_tx.size() == 0) begin
        miss++;
        $display("FAIL tx_unexpected: got byte %h at cycle %0d, want no o_TX_DV", tx_byte, cyc);
      end else begin
        e = exp_tx.pop_front();
        if (tx_byte !== e.v || (e.c >= 0 && cyc != e.c)) begin
          miss++;
          $display("FAIL tx_ack: got byte %h at cycle %0d, want %h at cycle %0d", tx_byte, cyc, e.v, e.c);
        end
      end
    end
    if ({game_start, game_reset, cmd_err} != P_NONE) begin
      vectors++;
      if (exp_p.size() == 0) begin
        miss++;
        $display("FAIL pulse_unexpected: got {start,reset,err}=%b at cycle %0d, want none", {game_start, game_reset, cmd_err}, cyc);
      end else begin
        e = exp_p.pop_front();
        if ({game_start, game_reset, cmd_err} !== e.v[2:0] || cyc != e.c) begin
          miss++;
          $display("FAIL pulse: got {start,reset,err}=%b at cycle %0d, want %b at cycle %0d", {game_start, game_reset, cmd_err}, cyc, e.v[2:0], e.c);
        end
      end
    end
  end
  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    vectors++;
    if (a !== e) begin
      miss++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic cmd(input logic [7:0] b, input logic [2:0] p, input logic [7:0] ack, input bit busy);
    if (p != P_NONE) exp_p.push_back('{{5'b0, p}, cyc + 1});
    if (ack != NOACK) exp_tx.push_back('{ack, busy ? -1 : cyc + 2});
    rx_dv = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv = 1'b0;
    rx_byte = 8'h00;
  endtask
  initial begin
    int n;
    rst = 1'b1;
    rx_dv = 1'b0;
    rx_byte = 8'h00;
    tx_active = 1'b0;
    idle(3);
    chk("reset_speed", {6'b0, speed}, 8'd1);
    chk("reset_pause", {7'b0, pause}, 8'd0);
    chk("reset_tx_byte", tx_byte, 8'h00);
    chk("reset_pulses", {4'b0, game_start, game_reset, cmd_err, tx_dv}, 8'h00);
    rst = 1'b0;
    idle(2);
    cmd(8'h53, P_START, K, 0);
    chk("start_pause", {7'b0, pause}, 8'd0);
    idle(3);
    cmd(8'h50, P_NONE, K, 0);
    chk("pause_on", {7'b0, pause}, 8'd1);
    idle(3);
    cmd(8'h50, P_NONE, K, 0);
    chk("pause_off", {7'b0, pause}, 8'd0);
    idle(3);
    cmd(8'h50, P_NONE, K, 0);
    chk("pause_on2", {7'b0, pause}, 8'd1);
    idle(3);
    cmd(8'h53, P_START, K, 0);
    chk("start_clears_pause", {7'b0, pause}, 8'd0);
    idle(3);
    cmd(8'h52, P_RESET, K, 0);
    idle(3);
    cmd(8'h44, P_NONE, NOACK, 0);
    idle(2);
    cmd(8'h03, P_NONE, K, 0);
    chk("speed_3", {6'b0, speed}, 8'd3);
    idle(3);
    cmd(8'h44, P_NONE, NOACK, 0);
    idle(2);
    cmd(8'h07, P_ERR, Q, 0);
    chk("speed_kept", {6'b0, speed}, 8'd3);
    idle(3);
    // timeout: error lands 1+TO cycles after the 'D' is driven
    n = cyc;
    exp_p.push_back('{{5'b0, P_ERR}, n + 1 + TO});
    exp_tx.push_back('{Q, n + 2 + TO});
    cmd(8'h44, P_NONE, NOACK, 0);
    idle(TO + 4);
    cmd(8'h53, P_START, K, 0);
    idle(3);
    // argument on the very cycle the timeout would fire wins
    n = cyc;
    cmd(8'h44, P_NONE, NOACK, 0);
    while (cyc < n + TO) @(negedge clk);
    cmd(8'h02, P_NONE, K, 0);
    chk("speed_edge", {6'b0, speed}, 8'd2);
    idle(4);
    // argument byte 'S' is not a start command
    cmd(8'h44, P_NONE, NOACK, 0);
    cmd(8'h53, P_ERR, Q, 0);
    chk("arg_s_speed", {6'b0, speed}, 8'd2);
    idle(3);
    // back-to-back: old 'K' goes out as '?' is queued, then '?'
    cmd(8'h50, P_NONE, K, 0);
    cmd(8'h5A, P_ERR, Q, 0);
    chk("b2b_pause", {7'b0, pause}, 8'd1);
    idle(4);
    tx_active = 1'b1;
    cmd(8'h53, P_START, NOACK, 1);
    idle(1);
    cmd(8'h5A, P_ERR, Q, 1);
    idle(5);
    tx_active = 1'b0;
    idle(5);
    tx_active = 1'b1;
    cmd(8'h50, P_NONE, NOACK, 1);
    chk("busy_pause", {7'b0, pause}, 8'd1);
    cmd(8'h44, P_NONE, NOACK, 1);
    idle(1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_pause", {7'b0, pause}, 8'd0);
    chk("rst_speed", {6'b0, speed}, 8'd1);
    tx_active = 1'b0;
    idle(4);
    cmd(8'h02, P_ERR, Q, 0);
    chk("post_rst_speed", {6'b0, speed}, 8'd1);
    idle(5);
    vectors++;
    if (exp_tx.size() != 0 || exp_p.size() != 0) begin
      miss++;
      $display("FAIL drain: got %0d acks and %0d pulses outstanding, want 0 and 0", exp_tx.size(), exp_p.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end
endmodule
